gray_pointer_sync_block: RTL and testbench

Parametrised multi-channel, multi-stage synchroniser for gray-coded FIFO pointers arriving from a foreign clock domain. Each channel is resampled through a configurable flop chain, then converted to binary. The block flags every pointer advance and detects illegal multi-bit gray steps. It replaces fixed two-flop pointer synchronisers on the FIFO full/empty comparison paths, and one instance can serve several FIFOs.

---
 rtl/gray_pointer_sync_block.sv | 92 +++++++++
 tb/tb_gray_pointer_sync_block.sv | 138 +++++++++++++
 2 files changed

// File: rtl/gray_pointer_sync_block.sv
// Multi-channel gray-pointer synchroniser: a flop chain per channel, then a
// registered gray-to-binary conversion, an advance pulse and a sticky
// illegal-step flag.
module gray_pointer_sync_block #(
  parameter int unsigned addr_size     = 3,
  parameter int unsigned sync_stages   = 2,
  parameter int unsigned channel_count = 1
) (
  input  logic                                     clock_i,
  input  logic                                     reset_i,
  input  logic [channel_count*(addr_size+1)-1:0]   gray_pointer_i,
  input  logic                                     clear_error_i,
  output logic [channel_count*(addr_size+1)-1:0]   gray_pointer_o,
  output logic [channel_count*(addr_size+1)-1:0]   binary_pointer_o,
  output logic [channel_count-1:0]                 pointer_update_o,
  output logic [channel_count-1:0]                 step_error_o,
  output logic                                     sync_valid_o
);

  localparam int unsigned W  = addr_size + 1;
  localparam int unsigned NW = channel_count * W;
  localparam int unsigned CW = $clog2(sync_stages + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(sync_stages + 1);

  logic [sync_stages-1:0][NW-1:0] chain_q;
  logic [NW-1:0]                  prev_q;
  logic [NW-1:0]                  bin_q, bin_d;
  logic [channel_count-1:0]       upd_q, upd_d;
  logic [channel_count-1:0]       err_q, err_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           valid_q, valid_d;

  // Binary bit i is the XOR of all gray bits at or above i.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < W; i++) b = b ^ (g >> i);
    return b;
  endfunction

  function automatic int unsigned ones(input logic [W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < W; i++) n = n + int'(v[i]);
    return n;
  endfunction

  // Next-state for conversion, update pulses, error flags and warm-up counter.
  always_comb begin
    bin_d   = '0;
    upd_d   = '0;
    err_d   = '0;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    valid_d = (cnt_d == CNT_MAX);
    for (int unsigned k = 0; k < channel_count; k++) begin
      bin_d[k*W +: W] = gray2bin(chain_q[sync_stages-1][k*W +: W]);
      upd_d[k] = valid_q && (chain_q[sync_stages-1][k*W +: W] != prev_q[k*W +: W]);
      // Set has priority over clear on the same edge.
      err_d[k] = (err_q[k] && !clear_error_i) ||
                 (upd_d[k] && (ones(chain_q[sync_stages-1][k*W +: W] ^ prev_q[k*W +: W]) > 1));
    end
  end

  // Synchroniser chain, conversion registers, flags and warm-up state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      chain_q <= '0;
      prev_q  <= '0;
      bin_q   <= '0;
      upd_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      chain_q[0] <= gray_pointer_i;
      for (int unsigned s = 1; s < sync_stages; s++) chain_q[s] <= chain_q[s-1];
      prev_q  <= chain_q[sync_stages-1];
      bin_q   <= bin_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign gray_pointer_o   = chain_q[sync_stages-1];
  assign binary_pointer_o = bin_q;
  assign pointer_update_o = upd_q;
  assign step_error_o     = err_q;
  assign sync_valid_o     = valid_q;

endmodule

// File: tb/tb_gray_pointer_sync_block.sv
// Directed bench for gray_pointer_sync_block (addr_size=3, 2 stages, 2 channels).
module tb_gray_pointer_sync_block;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       clear_error_i = 1'b0;
  logic [7:0] gray_pointer_i = '0;
  logic [7:0] gray_pointer_o;
  logic [7:0] binary_pointer_o;
  logic [1:0] pointer_update_o;
  logic [1:0] step_error_o;
  logic       sync_valid_o;

  int n_vec = 0;
  int n_bad = 0;

  gray_pointer_sync_block #(
    .addr_size    (3),
    .sync_stages  (2),
    .channel_count(2)
  ) dut (
    .clock_i         (clk),
    .reset_i         (reset_i),
    .gray_pointer_i  (gray_pointer_i),
    .clear_error_i   (clear_error_i),
    .gray_pointer_o  (gray_pointer_o),
    .binary_pointer_o(binary_pointer_o),
    .pointer_update_o(pointer_update_o),
    .step_error_o    (step_error_o),
    .sync_valid_o    (sync_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic [7:0] g;   // {ch1, ch0}
    logic [7:0] eg;
    logic [7:0] eb;
    logic [1:0] eu;
    logic [1:0] ee;
    logic       ev;
  } vec_t;

  vec_t tbl [27];

  task automatic apply(input string name, input logic rst, input logic clr,
                       input logic [7:0] g, input logic [7:0] eg, input logic [7:0] eb,
                       input logic [1:0] eu, input logic [1:0] ee, input logic ev);
    logic [20:0] act, exp;
    reset_i        = rst;
    clear_error_i  = clr;
    gray_pointer_i = g;
    @(posedge clk);
    #1;
    act = {gray_pointer_o, binary_pointer_o, pointer_update_o, step_error_o, sync_valid_o};
    exp = {eg, eb, eu, ee, ev};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got gray=%h bin=%h upd=%b err=%b valid=%b, expected gray=%h bin=%h upd=%b err=%b valid=%b",
               name, gray_pointer_o, binary_pointer_o, pointer_update_o, step_error_o, sync_valid_o,
               eg, eb, eu, ee, ev);
    end
  endtask

  // Gray code driven on channel 0 at step j of the full-count sequence.
  function automatic logic [3:0] drv(input int j);
    if (j >= 1 && j <= 15) return 4'(j ^ (j >> 1));
    return 4'h0;
  endfunction

  initial begin
    //           rst   clr   g      eg     eb     eu     ee     ev
    // reset held 3 cycles, then warm-up
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1};
    // ch1 illegal jump 0000 -> 0011, then clear
    tbl[6]  = '{1'b0, 1'b0, 8'h30, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'h30, 8'h30, 8'h00, 2'b00, 2'b00, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h30, 8'h30, 8'h20, 2'b10, 2'b10, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h30, 8'h30, 8'h20, 2'b00, 2'b10, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 8'h30, 8'h30, 8'h20, 2'b00, 2'b00, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h30, 8'h30, 8'h20, 2'b00, 2'b00, 1'b1};
    // ch0 0000 -> 0001 (legal), then 0001 -> 0010 with clear on detection edge
    tbl[12] = '{1'b0, 1'b0, 8'h31, 8'h30, 8'h20, 2'b00, 2'b00, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h31, 8'h31, 8'h20, 2'b00, 2'b00, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 8'h32, 8'h31, 8'h21, 2'b01, 2'b00, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'h32, 8'h32, 8'h21, 2'b00, 2'b00, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 8'h32, 8'h32, 8'h23, 2'b01, 2'b01, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 8'h32, 8'h32, 8'h23, 2'b00, 2'b01, 1'b1};
    tbl[18] = '{1'b0, 1'b1, 8'h32, 8'h32, 8'h23, 2'b00, 2'b00, 1'b1};
    // both channels to 0110 (ch0 legal, ch1 0011->0110 illegal), then reset
    tbl[19] = '{1'b0, 1'b0, 8'h66, 8'h32, 8'h23, 2'b00, 2'b00, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 8'h66, 8'h66, 8'h23, 2'b00, 2'b00, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 8'h66, 8'h66, 8'h44, 2'b11, 2'b10, 1'b1};
    tbl[22] = '{1'b1, 1'b0, 8'h66, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 8'h66, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 8'h66, 8'h66, 8'h00, 2'b00, 2'b00, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 8'h66, 8'h66, 8'h44, 2'b00, 2'b00, 1'b1};
    tbl[26] = '{1'b0, 1'b0, 8'h66, 8'h66, 8'h44, 2'b00, 2'b00, 1'b1};

    for (int i = 0; i < 27; i++)
      apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].clr, tbl[i].g,
            tbl[i].eg, tbl[i].eb, tbl[i].eu, tbl[i].ee, tbl[i].ev);

    // Input held constant: no pulses, outputs frozen
    for (int i = 0; i < 20; i++)
      apply($sformatf("hold%0d", i), 1'b0, 1'b0, 8'h66, 8'h66, 8'h44, 2'b00, 2'b00, 1'b1);

    // Fresh reset and warm-up with zero inputs
    apply("rst2", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0);
    apply("warm1", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0);
    apply("warm2", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0);
    apply("warm3", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1);

    // Full gray count on channel 0 incl. 1000 -> 0000 wrap; channel 1 stays 0
    for (int j = 1; j <= 20; j++) begin
      int m;
      logic [3:0] eb0;
      logic       up;
      m   = j - 2;
      eb0 = (m >= 1 && m <= 16) ? 4'(m % 16) : 4'h0;
      up  = (m >= 1 && m <= 16);
      apply($sformatf("count%0d", j), 1'b0, 1'b0, {4'h0, drv(j)},
            {4'h0, drv(j - 1)}, {4'h0, eb0}, {1'b0, up}, 2'b00, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
